// File: rtl/mmio_uart_bridge.sv
// Memory-mapped bridge from the cpu byte bus to RAM and the UART TX/RX FIFOs, cycle counter and stop flag.
// Read data has one cycle of latency (IO registered, RAM passed through); full TX FIFO drops writes and raises io_buffer_full.
module mmio_uart_bridge #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    input  logic [7:0]  ram_din,
    output logic        ram_we,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wr_q, tx_rd_q;
    logic [TAW:0]   tx_cnt_q, tx_cnt_d;
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wr_q, rx_rd_q;
    logic [RAW:0]   rx_cnt_q, rx_cnt_d;
    logic [31:0]    cyc_q, snap_q;
    logic [7:0]     io_rdata_q, io_rdata_d;
    logic           d1_io_sel_q, stop_pend_q, ibf_q, stop_q, ovf_q;

    logic       io_sel, wr_io, rd_io;
    logic [2:0] off;
    logic       tx_full, tx_pop, tx_req, tx_stop_push, tx_push;
    logic [7:0] tx_wdat;
    logic       rx_empty, rx_push, rx_pop;
    logic       unused_addr;

    assign unused_addr = ^{cpu_a[31:18], cpu_a[15:3]};

    assign io_sel = (cpu_a[17:16] == 2'b11);
    assign off    = cpu_a[2:0];
    assign wr_io  = cpu_wr & io_sel;
    assign rd_io  = ~cpu_wr & io_sel;
    assign ram_we = cpu_wr & ~io_sel;

    assign tx_full  = (tx_cnt_q == TX_FULL);
    assign tx_valid = (tx_cnt_q != '0);
    assign tx_data  = tx_mem[tx_rd_q];
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_req   = wr_io & (off == 3'd0) & (cpu_dout != 8'h00);
    // The stop marker only takes a slot the cpu is not competing for.
    assign tx_stop_push = stop_pend_q & ~tx_req & (~tx_full | tx_pop);
    assign tx_push  = (tx_req & (~tx_full | tx_pop)) | tx_stop_push;
    assign tx_wdat  = tx_req ? cpu_dout : 8'h00;
    assign tx_cnt_d = tx_cnt_q + {{TAW{1'b0}}, tx_push} - {{TAW{1'b0}}, tx_pop};

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_ready = (rx_cnt_q != RX_FULL) & rst_in;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rd_io & (off == 3'd0) & ~rx_empty;
    assign rx_cnt_d = rx_cnt_q + {{RAW{1'b0}}, rx_push} - {{RAW{1'b0}}, rx_pop};

    always_comb begin
        io_rdata_d = 8'h00;
        if (rd_io) begin
            case (off)
                3'd0:    io_rdata_d = rx_empty ? 8'h00 : rx_mem[rx_rd_q];
                3'd4:    io_rdata_d = cyc_q[7:0];
                3'd5:    io_rdata_d = snap_q[15:8];
                3'd6:    io_rdata_d = snap_q[23:16];
                3'd7:    io_rdata_d = snap_q[31:24];
                default: io_rdata_d = 8'h00;
            endcase
        end
    end

    assign cpu_din        = d1_io_sel_q ? io_rdata_q : ram_din;
    assign io_buffer_full = ibf_q;
    assign program_stop   = stop_q;
    assign tx_overflow    = ovf_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            tx_cnt_q    <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            rx_cnt_q    <= '0;
            cyc_q       <= '0;
            snap_q      <= '0;
            io_rdata_q  <= 8'h00;
            d1_io_sel_q <= 1'b1;    // selects io_rdata_q so cpu_din reads 0x00 out of reset
            stop_pend_q <= 1'b0;
            ibf_q       <= 1'b0;
            stop_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cyc_q       <= cyc_q + 32'd1;
            d1_io_sel_q <= io_sel;
            io_rdata_q  <= io_rdata_d;
            if (rd_io && off == 3'd4)
                snap_q <= cyc_q;

            if (tx_push) begin
                tx_mem[tx_wr_q] <= tx_wdat;
                tx_wr_q         <= tx_wr_q + 1'b1;
            end
            if (tx_pop)
                tx_rd_q <= tx_rd_q + 1'b1;
            tx_cnt_q <= tx_cnt_d;
            ibf_q    <= (tx_cnt_d == TX_FULL);
            if (tx_req && tx_full && !tx_pop)
                ovf_q <= 1'b1;

            if (tx_stop_push)
                stop_pend_q <= 1'b0;
            if (wr_io && off == 3'd4) begin
                stop_q      <= 1'b1;
                stop_pend_q <= 1'b1;
            end

            if (rx_push) begin
                rx_mem[rx_wr_q] <= rx_data;
                rx_wr_q         <= rx_wr_q + 1'b1;
            end
            if (rx_pop)
                rx_rd_q <= rx_rd_q + 1'b1;
            rx_cnt_q <= rx_cnt_d;
        end
    end
endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Directed bench for mmio_uart_bridge: RAM/IO reads, TX FIFO fill/overflow/drain, RX FIFO, counter snapshot.
module tb_mmio_uart_bridge;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_stop;
    logic        tx_overflow;

    int checks = 0;
    int failures = 0;
    logic [7:0]  tx_seen [$];
    logic [31:0] tb_cnt;

    mmio_uart_bridge #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
        .cpu_wr(cpu_wr), .cpu_din(cpu_din), .ram_din(ram_din), .ram_we(ram_we),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .program_stop(program_stop), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Handshakes are sampled mid-cycle; they complete at the following rising edge.
    always @(negedge clk_in)
        if (rst_in && tx_valid && tx_ready) tx_seen.push_back(tx_data);

    always @(posedge clk_in)
        if (!rst_in) tb_cnt <= 32'd0;
        else         tb_cnt <= tb_cnt + 32'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
    endtask

    task automatic io_wr(input logic [2:0] o, input logic [7:0] d);
        cpu_a = 32'h30000 | {29'd0, o}; cpu_wr = 1'b1; cpu_dout = d;
        tick();
        idle();
    endtask

    initial begin
        int n;
        int ok33;
        rst_in = 1'b0; idle(); ram_din = 8'h00; tx_ready = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0;
        tick(); tick();
        chk("rst_cpu_din", {24'd0, cpu_din}, 32'h00);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_flags", {28'd0, tx_valid, io_buffer_full, program_stop, tx_overflow}, 32'd0);
        rst_in = 1'b1;
        #1 chk("rx_ready_out_of_rst", {31'd0, rx_ready}, 32'd1);

        // RAM read and write decode
        cpu_a = 32'h00100;
        #1 chk("ram_we_read", {31'd0, ram_we}, 32'd0);
        tick();
        idle(); ram_din = 8'h5A;
        #1 chk("ram_read", {24'd0, cpu_din}, 32'h5A);
        cpu_a = 32'h00100; cpu_wr = 1'b1;
        #1 chk("ram_we_write", {31'd0, ram_we}, 32'd1);
        cpu_a = 32'h30000;
        #1 chk("ram_we_io_write", {31'd0, ram_we}, 32'd0);
        idle();

        // TX: 0x00 is never queued
        tx_ready = 1'b1;
        io_wr(3'd0, 8'h41); io_wr(3'd0, 8'h00); io_wr(3'd0, 8'h42);
        repeat (4) tick();
        chk("tx_count_2", tx_seen.size(), 2);
        if (tx_seen.size() == 2) begin
            chk("tx_first", {24'd0, tx_seen[0]}, 32'h41);
            chk("tx_second", {24'd0, tx_seen[1]}, 32'h42);
        end

        // TX fill, overflow, stop marker behind the queued bytes
        tx_ready = 1'b0; tx_seen.delete();
        for (int i = 0; i < 7; i++) io_wr(3'd0, 8'h33);
        chk("ibf_at_7", {31'd0, io_buffer_full}, 32'd0);
        io_wr(3'd0, 8'h33);
        chk("ibf_at_8", {31'd0, io_buffer_full}, 32'd1);
        chk("ovf_before", {31'd0, tx_overflow}, 32'd0);
        io_wr(3'd0, 8'h33);
        chk("ovf_after_9th", {31'd0, tx_overflow}, 32'd1);
        io_wr(3'd4, 8'h01);
        chk("program_stop", {31'd0, program_stop}, 32'd1);
        chk("tx_head_still_33", {24'd0, tx_data}, 32'h33);
        tx_ready = 1'b1;
        repeat (14) tick();
        chk("drain_count", tx_seen.size(), 9);
        n = tx_seen.size();
        ok33 = 0;
        for (int i = 0; i < n && i < 8; i++) if (tx_seen[i] == 8'h33) ok33++;
        chk("drain_33s", ok33, 8);
        if (n > 0) chk("drain_last_zero", {24'd0, tx_seen[n-1]}, 32'h00);
        chk("drain_empty", {30'd0, tx_valid, io_buffer_full}, 32'd0);

        // RX push and pop, including read of empty FIFO
        rx_valid = 1'b1; rx_data = 8'h10; tick();
        rx_data = 8'h20; tick();
        rx_valid = 1'b0;
        cpu_a = 32'h30000;
        tick(); chk("rx_pop_10", {24'd0, cpu_din}, 32'h10);
        tick(); chk("rx_pop_20", {24'd0, cpu_din}, 32'h20);
        tick(); chk("rx_pop_empty", {24'd0, cpu_din}, 32'h00);
        idle();
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'hA0 + 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        chk("rx_full_ready", {31'd0, rx_ready}, 32'd0);
        cpu_a = 32'h30000; tick(); idle();
        chk("rx_full_head", {24'd0, cpu_din}, 32'hA0);
        chk("rx_ready_after_pop", {31'd0, rx_ready}, 32'd1);
        cpu_a = 32'h30001; tick(); idle();
        chk("io_off1_zero", {24'd0, cpu_din}, 32'h00);

        // Mid-operation reset clears FIFOs and sticky flags
        rst_in = 1'b0; tick(); rst_in = 1'b1;
        chk("rst2_flags", {28'd0, tx_valid, io_buffer_full, program_stop, tx_overflow}, 32'd0);
        cpu_a = 32'h30000; tick(); idle();
        chk("rst2_rx_empty", {24'd0, cpu_din}, 32'h00);

        // Counter snapshot coherence
        n = 0;
        while (tb_cnt != 32'h123 && n < 1000) begin tick(); n++; end
        chk("cnt_reached", {31'd0, tb_cnt == 32'h123}, 32'd1);
        cpu_a = 32'h30004; tick(); chk("cnt_b0", {24'd0, cpu_din}, 32'h23);
        cpu_a = 32'h30005; tick(); chk("cnt_b1", {24'd0, cpu_din}, 32'h01);
        cpu_a = 32'h30006; tick(); chk("cnt_b2", {24'd0, cpu_din}, 32'h00);
        cpu_a = 32'h30007; tick(); chk("cnt_b3", {24'd0, cpu_din}, 32'h00);
        idle();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_uart_bridge.md
Name: mmio_uart_bridge

Overview:
Sits directly downstream of the cpu top on its byte-wide memory bus. It owns the RAM/IO address decode and provides the UART TX and RX FIFOs, the 0x30004 cycle counter and the program-stop flag. It drives the cpu's io_buffer_full input. It returns read data one cycle after the request, muxed between RAM and IO sources.

Parameters:
TX_DEPTH, 8, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous reset, active-low
cpu_a  in  32  cpu address bus; only [17:0] decoded
cpu_dout  in  8  cpu write data
cpu_wr  in  1  1 = write, 0 = read (a read is issued every cycle cpu_wr=0)
cpu_din  out  8  read data to cpu, valid the cycle after the request
ram_din  in  8  RAM read data (RAM returns data the cycle after the address)
ram_we  out  1  RAM write enable
io_buffer_full  out  1  to cpu; high when TX FIFO is full
tx_data  out  8  head of TX FIFO
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  UART transmitter accepts tx_data
rx_data  in  8  received byte
rx_valid  in  1  rx_data present
rx_ready  out  1  RX FIFO can accept
program_stop  out  1  sticky; set by a write to 0x30004
tx_overflow  out  1  sticky; a TX write was dropped

Behaviour:
- Decode: io_sel = (cpu_a[17:16]==2'b11). ram_we = cpu_wr & ~io_sel, combinational.
- Reset (rst_in=0 at a clock edge):
  - FIFOs empty; cycle counter = 0; snapshot = 0.
  - cpu_din = 0x00; program_stop = 0; tx_overflow = 0; stop_pending = 0.
  - tx_valid = 0 and io_buffer_full = 0 in the cycle after reset. rx_ready = 0 while rst_in=0.
  - A reset mid-operation discards all FIFO contents and any pending request.
- Read pipeline:
  - Stage register d1 captures {io_sel, cpu_a[2:0], read} each cycle, plus io_rdata computed from the request.
  - Next cycle: cpu_din = d1.io_sel ? io_rdata_q : ram_din. The mux is registered for IO and passes RAM through combinationally.
  - Latency is exactly 1 cycle for every read, including IO.
- IO reads (offset = cpu_a[2:0]):
  - 0: pop RX head and return it. If RX is empty, return 0x00 and pop nothing.
  - 4: latch snapshot <= cycle counter and return counter[7:0].
  - 5/6/7: return snapshot[15:8], [23:16] and [31:24] respectively, so a 4-byte read is coherent.
  - Any other offset: return 0x00 with no side effects.
- IO writes:
  - Offset 0 with data != 0x00: push into TX FIFO. Data 0x00 is ignored.
  - Offset 4: program_stop <= 1 and stop_pending <= 1.
  - Any other offset: ignored.
- TX FIFO:
  - Pop when tx_valid & tx_ready. Push is accepted if count < TX_DEPTH, or if a pop happens in the same cycle while full.
  - A push to a full FIFO with no pop is dropped and sets tx_overflow.
  - stop_pending pushes 0x00 in the first cycle with space and no cpu push, then clears.
  - io_buffer_full = (count == TX_DEPTH), registered from the next-state count.
- RX FIFO:
  - Push when rx_valid & rx_ready; rx_ready = ~rx_full & rst_in.
  - A simultaneous push and pop when full is not possible, because rx_ready is low when full.
  - A simultaneous push and pop when empty: the pop returns 0x00 and the pushed byte stays.
- Cycle counter: 32-bit, +1 every cycle out of reset, wraps 0xFFFFFFFF -> 0.
- Pointers: log2(DEPTH) bits plus a separate count of log2(DEPTH)+1 bits, so wrap-around is natural.

Test Plan:
- Reset, then cpu reads RAM at 0x00100 with ram_din=0x5A one cycle later -> cpu_din=0x5A in that cycle; ram_we stays 0.
- Writes 0x41,0x00,0x42 to 0x30000 with tx_ready=1 -> tx_data emits 0x41 then 0x42; 0x00 is never queued.
- tx_ready=0, 8 writes of 0x33 to 0x30000 -> io_buffer_full=1 after the 8th. A 9th write sets tx_overflow=1 and the FIFO keeps 8 entries. Raising tx_ready drains 8 bytes.
- Cycle counter wraps to 0; reads of 0x30004..0x30007 starting at counter 0x00000123 -> bytes 0x23,0x01,0x00,0x00, even though the counter advanced between reads.
- rx_valid pushes 0x10,0x20, then 3 reads of 0x30000 -> 0x10, 0x20, 0x00; rx_ready is low after RX_DEPTH pushes with no reads.
- Write 0x30004 while TX is full -> program_stop=1 immediately; 0x00 appears on tx_data only after the earlier bytes drain.
